// File: rtl/count_pkg.sv
// Shared types and default geometry for the streaming match counter.
// The optional saturating accumulator is enabled with COUNT_STREAM_SAT_EN.
package count_pkg;

  localparam int DEF_LANE_W    = 32;
  localparam int DEF_NUM_LANES = 16;
  localparam int DEF_LEN_W     = 16;
  localparam int DEF_CNT_W     = 32;
  localparam int DATA_W        = DEF_NUM_LANES * DEF_LANE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to hold a count of 0..lanes matches.
  function automatic int popcnt_w(input int lanes);
    return $clog2(lanes + 1);
  endfunction

  localparam int POPCNT_W = popcnt_w(DEF_NUM_LANES);

endpackage

// File: rtl/count_popcnt.sv
// Population count of one line's lane-match vector.
module count_popcnt #(
  parameter int NUM_LANES = 16,
  parameter int PC_W      = 5
) (
  input  logic [NUM_LANES-1:0] match,
  output logic [PC_W-1:0]      count
);

  // Sum of match bits; synthesis balances the chain into a tree.
  always_comb begin
    count = {PC_W{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      count = count + PC_W'(match[i]);
    end
  end

endmodule

// File: rtl/count_stream.sv
// Counts lanes equal to a key across a burst of wide lines (compare, popcount, accumulate).
// Define COUNT_STREAM_SAT_EN for a saturating accumulator; default wraps modulo 2^CNT_W.
module count_stream
  import count_pkg::*;
#(
  parameter int LANE_W    = DEF_LANE_W,
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int LEN_W     = DEF_LEN_W,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [LANE_W-1:0]           object,
  input  logic [LEN_W-1:0]            num_lines,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_LANES*LANE_W-1:0] data_set,
  output logic                        busy,
  output logic                        done,
  output logic [CNT_W-1:0]            result
);

  localparam int PC_W = popcnt_w(NUM_LANES);

  state_t                 state_r;
  state_t                 state_next_s;
  logic [LEN_W-1:0]       rem_r;
  logic [LANE_W-1:0]      obj_r;
  logic [NUM_LANES-1:0]   match_s;
  logic [NUM_LANES-1:0]   match_r;
  logic                   m_v_r;
  logic [PC_W-1:0]        pc_s;
  logic [CNT_W-1:0]       acc_r;
  logic [CNT_W-1:0]       acc_add_s;
  logic [CNT_W-1:0]       acc_next_s;
  logic                   start_acc_s;
  logic                   beat_s;
  logic                   in_ready_r;
  logic                   busy_r;
  logic                   done_r;
  logic [CNT_W-1:0]       result_r;

  assign beat_s   = in_valid && in_ready_r;
  assign in_ready = in_ready_r;
  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;

  // Job sequencing; DRAIN ends once no compared line is still waiting to be accumulated.
  always_comb begin
    state_next_s = state_r;
    start_acc_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          start_acc_s = 1'b1;
          if (num_lines == {LEN_W{1'b0}}) begin
            state_next_s = DONE;
          end else begin
            state_next_s = RUN;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (beat_s && (rem_r == LEN_W'(1))) begin
          state_next_s = DRAIN;
        end else begin
          state_next_s = RUN;
        end
      end
      DRAIN: begin
        if (!m_v_r) begin
          state_next_s = DONE;
        end else begin
          state_next_s = DRAIN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Lane-wise compare against the captured key.
  always_comb begin
    match_s = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      match_s[i] = (data_set[i*LANE_W +: LANE_W] == obj_r);
    end
  end

  count_popcnt #(
    .NUM_LANES (NUM_LANES),
    .PC_W      (PC_W)
  ) u_popcnt (
    .match (match_r),
    .count (pc_s)
  );

`ifdef COUNT_STREAM_SAT_EN
  localparam int SUM_W = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
  logic [SUM_W-1:0] sum_s;

  assign sum_s     = {{(SUM_W-CNT_W){1'b0}}, acc_r} + {{(SUM_W-PC_W){1'b0}}, pc_s};
  assign acc_add_s = (|sum_s[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : sum_s[CNT_W-1:0];
`else
  assign acc_add_s = acc_r + CNT_W'(pc_s);
`endif

  // Accumulator restarts at zero on every accepted job.
  always_comb begin
    acc_next_s = acc_r;
    if (start_acc_s) begin
      acc_next_s = {CNT_W{1'b0}};
    end else if (m_v_r) begin
      acc_next_s = acc_add_s;
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Control state and registered status outputs, decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      rem_r      <= {LEN_W{1'b0}};
      obj_r      <= {LANE_W{1'b0}};
      in_ready_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      result_r   <= {CNT_W{1'b0}};
    end else begin
      state_r    <= state_next_s;
      in_ready_r <= (state_next_s == RUN);
      busy_r     <= (state_next_s != IDLE);
      done_r     <= (state_next_s == DONE);
      if (start_acc_s) begin
        rem_r <= num_lines;
        obj_r <= object;
      end else if (beat_s) begin
        rem_r <= rem_r - LEN_W'(1);
      end
      if (state_next_s == DONE) begin
        result_r <= acc_next_s;
      end
    end
  end

  // Datapath pipeline: match vector stage, then accumulate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_r <= {NUM_LANES{1'b0}};
      m_v_r   <= 1'b0;
      acc_r   <= {CNT_W{1'b0}};
    end else begin
      m_v_r <= beat_s;
      acc_r <= acc_next_s;
      if (beat_s) begin
        match_r <= match_s;
      end
    end
  end

endmodule
